booth_digit_gen: RTL

- Sequential radix-16 Booth recoder for the multiplier operand. Pairs with the partial-product shift register on the accumulate side.
- Loads the multiplier once, then emits one signed Booth digit (-8..+8) per accepted handshake, least-significant group first.
- Feeds the PP generator/adder, which consumes one digit per step and shifts the partial product 4 bits.

---
 rtl/mul_pkg.sv | 20 ++
 rtl/booth16_enc.sv | 25 ++
 rtl/booth_digit_gen.sv | 105 ++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared multiplier types: operand width, Booth digit format and recoder FSM states.
// Digit width and counter sizing are derived from WIDTH here.
package mul_pkg;

  localparam int WIDTH = 32;
  localparam int NDIG  = WIDTH / 4;
  // Room for NDIG+1 digits in the unsigned build without the counter wrapping.
  localparam int CNT_W = $clog2(NDIG + 2);

  typedef struct packed {
    logic       sign;
    logic [3:0] mag;
  } booth_digit_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } bdg_state_t;

endpackage

// File: rtl/booth16_enc.sv
// Radix-16 Booth encoder: 5-bit group {b3,b2,b1,b0,prev} -> signed digit in -8..+8.
// Purely combinational, so the PP selector can reuse it for checking.
module booth16_enc
  import mul_pkg::*;
(
  input  logic [4:0]   i_group,
  output booth_digit_t o_digit
);

  logic signed [4:0] w_val;
  logic        [4:0] w_abs;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_val   = '0;
    w_abs   = '0;
    o_digit = '0;
    // Sign-extend the nibble and add the previous group's top bit.
    w_val   = $signed({i_group[4], i_group[4:1]}) + $signed({4'b0000, i_group[0]});
    w_abs   = w_val[4] ? 5'(-w_val) : w_val;
    o_digit.sign = w_val[4];
    o_digit.mag  = w_abs[3:0];
  end

endmodule

// File: rtl/booth_digit_gen.sv
// Sequential radix-16 Booth recoder: loads the multiplier, then emits one digit per accept, LSB first.
// Define BOOTH_UNSIGNED_EN to add is_signed; unsigned operands get one extra final digit.
module booth_digit_gen
  import mul_pkg::*;
#(
  parameter int WIDTH = mul_pkg::WIDTH,
  parameter int NDIG  = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef BOOTH_UNSIGNED_EN
  input  logic             is_signed,
`endif
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             dig_valid,
  input  logic             dig_ready,
  output logic             dig_sign,
  output logic [3:0]       dig_mag,
  output logic             dig_last,
  output logic             done
);

  localparam int CW = $clog2(NDIG + 2);

  bdg_state_t       r_state;
  logic [WIDTH-1:0] r_sr;
  logic             r_prev;
  logic [CW-1:0]    r_cnt;
  logic             r_done;
  logic             r_ext;

  booth_digit_t     w_digit;
  logic             w_run;
  logic             w_accept;
  logic             w_last;
  logic             w_fill;
  logic             w_load_ext;
  logic [CW-1:0]    w_last_idx;

  booth16_enc u_enc (
    .i_group (({r_sr[3:0], r_prev})),
    .o_digit (w_digit)
  );

`ifdef BOOTH_UNSIGNED_EN
  // Unsigned operands shift in zeros, so the extra digit sees group 0000 plus prev.
  assign w_load_ext = ~is_signed;
  assign w_fill     = r_sr[WIDTH-1] & ~r_ext;
`else
  assign w_load_ext = 1'b0;
  assign w_fill     = r_sr[WIDTH-1];
`endif

  assign w_run      = (r_state == RUN);
  assign w_last_idx = CW'(NDIG - 1) + CW'(r_ext);
  assign w_last     = w_run && (r_cnt == w_last_idx);
  assign w_accept   = w_run && dig_ready;

  assign busy      = w_run;
  assign dig_valid = w_run;
  assign dig_sign  = w_run & w_digit.sign;
  assign dig_mag   = w_run ? w_digit.mag : 4'd0;
  assign dig_last  = w_last;
  assign done      = r_done;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sr    <= '0;
      r_prev  <= 1'b0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_ext   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_sr    <= din;
            r_prev  <= 1'b0;
            r_cnt   <= '0;
            r_ext   <= w_load_ext;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (w_accept) begin
            r_prev <= r_sr[3];
            r_sr   <= {{4{w_fill}}, r_sr[WIDTH-1:4]};
            r_cnt  <= r_cnt + CW'(1);
            if (w_last) begin
              r_state <= IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
